// File: rtl/urv_mem_io_pkg.sv
// Shared constants, load FSM state type and STATUS word builder for urv_mem_io.
package urv_mem_io_pkg;

  localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_LVL_LSB = 4;

  localparam logic [7:0] HALT_BYTE = 8'hFF;

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} load_state_t;

  // The level field is four bits wide, so deeper FIFOs report 15 when fuller.
  function automatic logic [31:0] status_word(input logic full, input logic empty,
                                              input logic [31:0] level);
    logic [31:0] w;
    w = 32'h0000_0000;
    w[ST_FULL] = full;
    w[ST_EMPTY] = empty;
    w[ST_LVL_LSB +: 4] = (level > 32'd15) ? 4'hF : level[3:0];
    return w;
  endfunction

endpackage

// File: rtl/urv_sync_fifo.sv
// First-word-fall-through synchronous FIFO with wrap-bit pointers.
module urv_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic [WIDTH-1:0]           head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Forcing zero when empty keeps the head defined before the storage is written.
  assign head    = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/urv_mem_io.sv
// Memory and console subsystem for urv_cpu: instruction port, byte-enabled data
// port with load wait states, buffered TX console, STATUS register and halt flag.
module urv_mem_io
  import urv_mem_io_pkg::*;
#(
  parameter int          MEM_WORDS = 16384,
  parameter int          ADDR_BITS = 16,
  parameter int          LOAD_WAIT = 0,
  parameter logic [31:0] IO_BASE   = 32'h1000_0000,
  parameter int          TX_DEPTH  = 8,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] im_addr_i,
  output logic [31:0] im_data_o,
  output logic        im_valid_o,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_data_s_i,
  input  logic [3:0]  dm_data_select_i,
  input  logic        dm_store_i,
  input  logic        dm_load_i,
  output logic [31:0] dm_data_l_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic        dm_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        halt_o
);

  localparam int IDX_BITS = ADDR_BITS - 2;
  localparam int TX_AW    = $clog2(TX_DEPTH);

  logic [31:0] ram [MEM_WORDS];

  logic [IDX_BITS-1:0] dm_idx;
  logic [IDX_BITS-1:0] im_idx;
  logic                is_tx;
  logic                is_status;
  logic                load_busy;
  logic                store_acc;
  logic                load_acc;
  logic                ram_we;
  logic                tx_push;
  logic                tx_pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic [TX_AW:0]      fifo_level;
  logic [7:0]          fifo_head;
  logic [31:0]         load_rdata;
  load_state_t         state_r;
  load_state_t         state_n;
  logic [2:0]          cnt_r;
  logic [2:0]          cnt_n;
  logic                done_n;
  logic                unused_bits;

  assign unused_bits = ^{im_addr_i[31:ADDR_BITS], im_addr_i[1:0]};

  assign dm_idx    = dm_addr_i[ADDR_BITS-1:2];
  assign im_idx    = im_addr_i[ADDR_BITS-1:2];
  assign is_tx     = (dm_addr_i == (IO_BASE + TXDATA_OFS));
  assign is_status = (dm_addr_i == (IO_BASE + STATUS_OFS));
  assign load_busy = (state_r == S_WAIT);

  // A full FIFO blocks TXDATA pushes even if the sink pops in the same cycle.
  assign dm_ready_o = !load_busy && !(dm_store_i && is_tx && fifo_full);
  assign store_acc  = dm_store_i && dm_ready_o;
  assign load_acc   = dm_load_i && !dm_store_i && dm_ready_o;
  assign ram_we     = store_acc && !is_tx && !is_status;
  assign tx_push    = store_acc && is_tx;
  assign tx_pop     = tx_ready_i && !fifo_empty;
  assign tx_valid_o = !fifo_empty;
  assign tx_data_o  = fifo_head;

  urv_sync_fifo #(
    .WIDTH (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .push      (tx_push),
    .push_data (dm_data_s_i[7:0]),
    .pop       (tx_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level),
    .head      (fifo_head)
  );

  always_comb begin
    load_rdata = ram[dm_idx];
    if (is_tx) begin
      load_rdata = 32'h0000_0000;
    end else if (is_status) begin
      load_rdata = status_word(fifo_full, fifo_empty, 32'(fifo_level));
    end else begin
      load_rdata = ram[dm_idx];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_we && dm_data_select_i[b]) ram[dm_idx][8*b +: 8] <= dm_data_s_i[8*b +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      im_data_o  <= 32'h0000_0000;
      im_valid_o <= 1'b0;
    end else begin
      im_data_o  <= ram[im_idx];
      im_valid_o <= 1'b1;
    end
  end

  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    done_n  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (load_acc) begin
          if (LOAD_WAIT == 0) begin
            done_n = 1'b1;
          end else begin
            state_n = S_WAIT;
            cnt_n   = 3'(LOAD_WAIT);
          end
        end else begin
          state_n = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_r == 3'd1) begin
          state_n = S_IDLE;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt_r - 3'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Load data is captured at the accept edge and held until the done pulse.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r         <= S_IDLE;
      cnt_r           <= 3'd0;
      dm_load_done_o  <= 1'b0;
      dm_store_done_o <= 1'b0;
      dm_data_l_o     <= 32'h0000_0000;
      halt_o          <= 1'b0;
    end else begin
      state_r         <= state_n;
      cnt_r           <= cnt_n;
      dm_load_done_o  <= done_n;
      dm_store_done_o <= store_acc;
      if (load_acc) dm_data_l_o <= load_rdata;
      if (tx_push && (dm_data_s_i[7:0] == HALT_BYTE)) halt_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_urv_mem_io.sv
// Directed scoreboard bench for urv_mem_io with three load wait states and an 8-deep TX FIFO.
module tb_urv_mem_io;

  localparam logic [31:0] IO = 32'h1000_0000;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic [31:0] im_addr_i;
  logic [31:0] im_data_o;
  logic        im_valid_o;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_data_s_i;
  logic [3:0]  dm_data_select_i;
  logic        dm_store_i;
  logic        dm_load_i;
  logic [31:0] dm_data_l_o;
  logic        dm_load_done_o;
  logic        dm_store_done_o;
  logic        dm_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i;
  logic        halt_o;

  urv_mem_io #(
    .MEM_WORDS (1024),
    .ADDR_BITS (12),
    .LOAD_WAIT (3),
    .IO_BASE   (IO),
    .TX_DEPTH  (8),
    .INIT_FILE ("")
  ) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n_i),
    .im_addr_i        (im_addr_i),
    .im_data_o        (im_data_o),
    .im_valid_o       (im_valid_o),
    .dm_addr_i        (dm_addr_i),
    .dm_data_s_i      (dm_data_s_i),
    .dm_data_select_i (dm_data_select_i),
    .dm_store_i       (dm_store_i),
    .dm_load_i        (dm_load_i),
    .dm_data_l_o      (dm_data_l_o),
    .dm_load_done_o   (dm_load_done_o),
    .dm_store_done_o  (dm_store_done_o),
    .dm_ready_o       (dm_ready_o),
    .tx_data_o        (tx_data_o),
    .tx_valid_o       (tx_valid_o),
    .tx_ready_i       (tx_ready_i),
    .halt_o           (halt_o)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] exp_load_q[$];
  logic [7:0]  exp_tx_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] sel);
    int cyc;
    dm_addr_i = addr;
    dm_data_s_i = data;
    dm_data_select_i = sel;
    dm_store_i = 1'b1;
    #1;
    cyc = 0;
    while (!dm_ready_o && cyc < 40) begin
      @(negedge clk); #1;
      cyc++;
    end
    if (!dm_ready_o) check("store_accept_timeout", {31'b0, dm_ready_o}, 32'd1);
    @(posedge clk);
    if (addr == IO) exp_tx_q.push_back(data[7:0]);
    @(negedge clk);
    dm_store_i = 1'b0;
    check("store_done", {31'b0, dm_store_done_o}, 32'd1);
  endtask

  // Expected data is pushed at the accept edge and popped when done appears.
  task automatic load(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    int cyc;
    int lat;
    int busy;
    dm_addr_i = addr;
    dm_load_i = 1'b1;
    #1;
    cyc = 0;
    while (!dm_ready_o && cyc < 40) begin
      @(negedge clk); #1;
      cyc++;
    end
    @(posedge clk);
    exp_load_q.push_back(exp);
    @(negedge clk);
    dm_load_i = 1'b0;
    lat = 1;
    busy = 0;
    while (!dm_load_done_o && lat < 20) begin
      if (!dm_ready_o) busy++;
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd4);
    check({tag, "_busy_cycles"}, 32'(busy), 32'd3);
    check({tag, "_data"}, dm_data_l_o, exp_load_q.pop_front());
  endtask

  initial begin
    int cyc;
    logic seen_done;
    rst_n_i = 1'b0;
    im_addr_i = 32'h0;
    dm_addr_i = 32'h0;
    dm_data_s_i = 32'h0;
    dm_data_select_i = 4'h0;
    dm_store_i = 1'b0;
    dm_load_i = 1'b0;
    tx_ready_i = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_im_valid", {31'b0, im_valid_o}, 32'd0);
    check("rst_im_data", im_data_o, 32'h0);
    check("rst_load_data", dm_data_l_o, 32'h0);
    check("rst_load_done", {31'b0, dm_load_done_o}, 32'd0);
    check("rst_store_done", {31'b0, dm_store_done_o}, 32'd0);
    check("rst_ready", {31'b0, dm_ready_o}, 32'd1);
    check("rst_tx_valid", {31'b0, tx_valid_o}, 32'd0);
    check("rst_tx_data", {24'b0, tx_data_o}, 32'h0);
    check("rst_halt", {31'b0, halt_o}, 32'd0);

    rst_n_i = 1'b1;
    @(negedge clk);
    check("im_valid_after_reset", {31'b0, im_valid_o}, 32'd1);

    // Instruction fetch of a word written through the data port.
    store(32'h0000_0010, 32'h1122_3344, 4'hF);
    im_addr_i = 32'h0000_0010;
    @(negedge clk);
    check("im_fetch", im_data_o, 32'h1122_3344);
    check("im_fetch_valid", {31'b0, im_valid_o}, 32'd1);

    // Partial store, read-after-write load, empty-select store.
    store(32'h0000_0020, 32'h0000_0000, 4'hF);
    store(32'h0000_0020, 32'hAABB_CCDD, 4'b0101);
    load("raw_partial", 32'h0000_0020, 32'h00BB_00DD);
    store(32'h0000_0020, 32'hFFFF_FFFF, 4'b0000);
    load("sel_none", 32'h0000_0020, 32'h00BB_00DD);
    load("txdata_read", IO, 32'h0);
    load("status_empty", IO + 32'd4, 32'h0000_0002);

    // Fill the FIFO, then a ninth push must stall.
    for (int i = 0; i < 8; i++) store(IO, 32'h41 + 32'(i), 4'hF);
    load("status_full", IO + 32'd4, 32'h0000_0081);
    dm_addr_i = IO;
    dm_data_s_i = 32'h0000_0049;
    dm_data_select_i = 4'hF;
    dm_store_i = 1'b1;
    #1;
    check("stall_full", {31'b0, dm_ready_o}, 32'd0);
    @(negedge clk); #1;
    check("stall_held", {31'b0, dm_ready_o}, 32'd0);
    tx_ready_i = 1'b1;
    #1;
    check("stall_pop_same_cycle", {31'b0, dm_ready_o}, 32'd0);
    check("tx_first_head", {24'b0, tx_data_o}, {24'b0, exp_tx_q.pop_front()});
    @(negedge clk);
    tx_ready_i = 1'b0;
    #1;
    check("stall_release", {31'b0, dm_ready_o}, 32'd1);
    @(posedge clk);
    exp_tx_q.push_back(8'h49);
    @(negedge clk);
    dm_store_i = 1'b0;
    check("ninth_store_done", {31'b0, dm_store_done_o}, 32'd1);

    tx_ready_i = 1'b1;
    cyc = 0;
    while (tx_valid_o && cyc < 20) begin
      check("tx_drain", {24'b0, tx_data_o}, {24'b0, exp_tx_q.pop_front()});
      @(negedge clk);
      cyc++;
    end
    tx_ready_i = 1'b0;
    check("tx_drain_count", 32'(cyc), 32'd8);
    check("tx_drain_left", 32'(exp_tx_q.size()), 32'd0);

    // Halt byte is enqueued and sticky until reset.
    store(IO, 32'h0000_00FF, 4'h0);
    check("halt_set", {31'b0, halt_o}, 32'd1);
    check("halt_tx_valid", {31'b0, tx_valid_o}, 32'd1);
    check("halt_tx_byte", {24'b0, tx_data_o}, {24'b0, exp_tx_q.pop_front()});
    repeat (3) @(negedge clk);
    check("halt_sticky", {31'b0, halt_o}, 32'd1);
    #2;
    rst_n_i = 1'b0;
    #1;
    check("halt_async_clear", {31'b0, halt_o}, 32'd0);
    check("halt_rst_tx_valid", {31'b0, tx_valid_o}, 32'd0);
    @(negedge clk);
    rst_n_i = 1'b1;
    @(negedge clk);

    // Store and load together: store wins, no load done.
    dm_addr_i = 32'h0000_0030;
    dm_data_s_i = 32'h5A5A_5A5A;
    dm_data_select_i = 4'hF;
    dm_store_i = 1'b1;
    dm_load_i = 1'b1;
    #1;
    check("both_ready", {31'b0, dm_ready_o}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    dm_store_i = 1'b0;
    dm_load_i = 1'b0;
    check("both_store_done", {31'b0, dm_store_done_o}, 32'd1);
    seen_done = dm_load_done_o;
    repeat (6) begin
      @(negedge clk);
      seen_done = seen_done | dm_load_done_o;
    end
    check("both_no_load_done", {31'b0, seen_done}, 32'd0);
    load("both_readback", 32'h0000_0030, 32'h5A5A_5A5A);

    // Reset during a waiting load discards it.
    dm_addr_i = 32'h0000_0030;
    dm_load_i = 1'b1;
    #1;
    @(posedge clk);
    @(negedge clk);
    dm_load_i = 1'b0;
    check("wait_busy", {31'b0, dm_ready_o}, 32'd0);
    #2;
    rst_n_i = 1'b0;
    #1;
    check("wait_rst_ready", {31'b0, dm_ready_o}, 32'd1);
    @(negedge clk);
    rst_n_i = 1'b1;
    seen_done = dm_load_done_o;
    repeat (6) begin
      @(negedge clk);
      seen_done = seen_done | dm_load_done_o;
    end
    check("wait_rst_no_done", {31'b0, seen_done}, 32'd0);
    check("wait_rst_ready_after", {31'b0, dm_ready_o}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
